d_sram2axi_bridge: RTL and testbench
====================================

Name: d_sram2axi_bridge

Overview:
- Converts the data cache's downstream SRAM-like port (req/wr/size/addr/wdata, addr_ok/data_ok handshake) into single-beat AXI4 read and write transactions.
- Sits directly below d_cache and above the AXI interconnect.
- Holds one transaction outstanding at a time. Write-back and refill requests from the cache are serialized through it.

Parameters:
- AXI_ID, 4'd1, constant ID driven on arid/awid; the response ID is not checked.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- data_req  in  1  cache requests a memory access
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- data_addr  in  32  byte address
- data_wdata  in  32  write data
- data_rdata  out  32  read data
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  transaction complete this cycle
- arid/araddr/arlen/arsize/arburst  out  4/32/8/3/2  AXI read address
- arvalid  out  1; arready  in  1
- rid/rdata/rresp/rlast  in  4/32/2/1; rvalid  in  1; rready  out  1
- awid/awaddr/awlen/awsize/awburst  out  4/32/8/3/2  AXI write address
- awvalid  out  1; awready  in  1
- wdata/wstrb/wlast  out  32/4/1; wvalid  out  1; wready  in  1
- bid/bresp  in  4/2; bvalid  in  1; bready  out  1

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset state is IDLE.
- Reset values of registered outputs: arvalid = awvalid = wvalid = 0; rready = bready = 0; req_* registers = 0.
- IDLE:
  - data_addr_ok = data_req, combinational in the same cycle.
  - On data_req, latch addr, size, wdata and wr into req_* registers.
  - Next state: WR_REQ if wr, else RD_ADDR.
- Acceptance limit: data_addr_ok is 0 in every state other than IDLE.
- RD_ADDR:
  - arvalid = 1, araddr = req_addr.
  - On arready, go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid & rlast: data_data_ok = 1 and data_rdata = rdata, both combinational in the same cycle; go to IDLE.
  - rvalid without rlast is ignored (never occurs with arlen = 0).
- WR_REQ:
  - awvalid and wvalid both assert on entry.
  - Each drops independently after its own handshake. Track completion with aw_done / w_done flags.
  - AW and W may complete in the same cycle or in either order.
  - Go to WR_RESP in the cycle both are done; when both complete together, that is one cycle.
- WR_RESP:
  - bready = 1.
  - On bvalid: data_data_ok = 1 for one cycle; go to IDLE.
  - data_rdata is don't-care for writes; drive rdata.
- Fixed AXI fields:
  - arlen = awlen = 0; arburst = awburst = 2'b01 (INCR); wlast = 1.
  - arsize = awsize = {1'b0, size}, with size 3 mapped to 2.
- Addresses: passed through unmodified from the latch.
- wstrb:
  - byte: one-hot on addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- wdata = req_wdata, not shifted; the cache supplies lane-aligned data.
- Error responses: rresp/bresp errors are ignored and the transaction still completes with data_data_ok.
- data_data_ok: asserted exactly once per accepted request; never in the same cycle as data_addr_ok.
- Back-to-back requests: a new request is accepted no earlier than the cycle after data_data_ok. Minimum read latency is 2 cycles, from addr_ok to data_ok with zero-wait AXI.
- Inputs after acceptance: data_req and the data_* inputs are not observed outside IDLE.
- Reset mid-transaction: immediate return to IDLE and all valids/readies drop. The interconnect shares the same reset.

Test Plan:
- Word read, addr 0x1FC0_0010, arready after 2 cycles, rdata 0xDEADBEEF with rlast one cycle later:
  - addr_ok in cycle 0; arvalid held until the handshake; arsize = 2, arlen = 0.
  - data_ok pulses with data_rdata = 0xDEADBEEF.
- Byte write, addr 0x0000_0103, wdata 0xAB000000, awready and wready in the same cycle, bvalid one cycle later:
  - wstrb = 4'b1000, awsize = 0.
  - Single data_ok on the B handshake.
- Word write with wready 3 cycles before awready:
  - wvalid drops after its handshake; awvalid stays high.
  - WR_RESP is entered only after AW completes; exactly one data_ok.
- Half write at addr 0x…2 with bresp = 2'b10 (SLVERR): wstrb = 4'b1100; data_ok still asserted and FSM returns to IDLE.
- data_req held high during a read, then a write back-to-back:
  - Second addr_ok no earlier than the cycle after the first data_ok.
  - No overlapping AR/AW valids.
- rst asserted while in RD_DATA:
  - arvalid/rready/data_ok go low asynchronously.
  - After release, a new read is accepted in IDLE with correct araddr.

Source files
------------

// File: rtl/d_sram2axi_bridge.sv
// d_sram2axi_bridge: serializes the data cache's SRAM-like requests into single-beat AXI4 reads and writes,
// one transaction outstanding at a time.
module d_sram2axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
  state_t      state_q, state_d;
  logic        req_wr_q, req_wr_d;
  logic [1:0]  req_size_q, req_size_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [1:0]  sz;
  logic        unused;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_wr_q    <= req_wr_d;
      req_size_q  <= req_size_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    req_wr_d    = req_wr_q;
    req_size_d  = req_size_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    aw_done_d   = 1'b0;
    w_done_d    = 1'b0;
    case (state_q)
      IDLE: if (data_req) begin
        state_d     = data_wr ? WR_REQ : RD_ADDR;
        req_wr_d    = data_wr;
        req_size_d  = data_size;
        req_addr_d  = data_addr;
        req_wdata_d = data_wdata;
      end
      RD_ADDR: state_d = arready ? RD_DATA : RD_ADDR;
      RD_DATA: state_d = (rvalid && rlast) ? IDLE : RD_DATA;
      WR_REQ: begin
        // AW and W channels finish independently; leave only once both have handshaken
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR_REQ;
      end
      WR_RESP: state_d = bvalid ? IDLE : WR_RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    arvalid      = state_q == RD_ADDR;
    rready       = state_q == RD_DATA;
    awvalid      = state_q == WR_REQ && !aw_done_q;
    wvalid       = state_q == WR_REQ && !w_done_q;
    bready       = state_q == WR_RESP;
    data_addr_ok = state_q == IDLE && data_req;
    data_data_ok = (rready && rvalid && rlast) || (bready && bvalid);
  end
  assign sz         = (req_size_q == 2'd3) ? 2'd2 : req_size_q;
  assign data_rdata = rdata;
  assign arid       = AXI_ID;
  assign awid       = AXI_ID;
  assign araddr     = req_addr_q;
  assign awaddr     = req_addr_q;
  assign arlen      = 8'd0;
  assign awlen      = 8'd0;
  assign arsize     = {1'b0, sz};
  assign awsize     = {1'b0, sz};
  assign arburst    = 2'b01;
  assign awburst    = 2'b01;
  assign wlast      = 1'b1;
  assign wdata      = req_wdata_q;
  assign wstrb      = (sz == 2'd0) ? (4'b0001 << req_addr_q[1:0]) :
                      (sz == 2'd1) ? (req_addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign unused     = ^{rid, rresp, bid, bresp, req_wr_q};
endmodule

// File: tb/tb_d_sram2axi_bridge.sv
// tb_d_sram2axi_bridge: directed stimulus with a transaction-level model checked every cycle,
// plus literal expectations for the key points of each scenario.
module tb_d_sram2axi_bridge;
  logic        clk = 1'b0, rst = 1'b1;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [31:0] data_addr = 0, data_wdata = 0, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, rid = 0, bid = 0;
  logic [31:0] araddr, awaddr, rdata = 0, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp = 0, bresp = 0;
  logic        arvalid, arready = 0, rlast = 0, rvalid = 0, rready;
  logic        awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid = 0, bready;
  logic [3:0]  wstrb;
  int total = 0, bad = 0;

  d_sram2axi_bridge dut (
    .clk(clk), .rst(rst), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: one outstanding transaction, tracked by which channel handshakes have happened
  logic        m_busy = 0, m_wr = 0, ar_hs = 0, aw_hs = 0, w_hs = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [1:0]  m_size = 0;
  always @(negedge clk) begin
    logic e_arv, e_rr, e_awv, e_wv, e_br, e_dok;
    logic [1:0] es;
    logic [3:0] ew;
    if (rst) begin
      m_busy = 0;
      chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, data_data_ok}, 0);
    end else begin
      es    = (m_size == 2'd3) ? 2'd2 : m_size;
      ew    = es == 0 ? 4'(1 << m_addr[1:0]) : es == 1 ? (m_addr[1] ? 4'hC : 4'h3) : 4'hF;
      e_arv = m_busy && !m_wr && !ar_hs;
      e_rr  = m_busy && !m_wr && ar_hs;
      e_awv = m_busy && m_wr && !aw_hs;
      e_wv  = m_busy && m_wr && !w_hs;
      e_br  = m_busy && m_wr && aw_hs && w_hs;
      e_dok = (e_rr && rvalid && rlast) || (e_br && bvalid);
      chk("addr_ok", data_addr_ok, !m_busy && data_req);
      chk("handshake_sigs", {arvalid, rready, awvalid, wvalid, bready}, {e_arv, e_rr, e_awv, e_wv, e_br});
      chk("data_ok", data_data_ok, e_dok);
      if (e_arv) chk("ar_fields", {arid, araddr, arlen, arsize, arburst}, {4'd1, m_addr, 8'd0, 1'b0, es, 2'b01});
      if (e_awv) chk("aw_fields", {awid, awaddr, awlen, awsize, awburst}, {4'd1, m_addr, 8'd0, 1'b0, es, 2'b01});
      if (e_wv) begin
        chk("w_data", wdata, m_wdata);
        chk("w_strb_last", {wstrb, wlast}, {ew, 1'b1});
      end
      if (e_dok && !m_wr) chk("rdata", data_rdata, rdata);
      if (!m_busy) begin
        if (data_req) begin
          m_busy = 1; m_wr = data_wr; m_addr = data_addr; m_wdata = data_wdata; m_size = data_size;
          ar_hs = 0; aw_hs = 0; w_hs = 0;
        end
      end else if (e_dok) m_busy = 0;
      else begin
        if (e_arv && arready) ar_hs = 1;
        if (e_awv && awready) aw_hs = 1;
        if (e_wv && wready) w_hs = 1;
      end
    end
  end

  task automatic req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    @(negedge clk);
    chk("reset_state", {arvalid, awvalid, wvalid, rready, bready}, 0);
    step();
    rst = 0;
    // word read with arready after 2 cycles
    req(0, 2, 32'h1FC0_0010, 0);
    @(negedge clk); chk("t1_addr_ok", data_addr_ok, 1);
    step(); data_req = 0;
    @(negedge clk); chk("t1_ar", {arvalid, arsize, arlen, araddr}, {1'b1, 3'd2, 8'd0, 32'h1FC0_0010});
    step(); step(); arready = 1;
    @(negedge clk); chk("t1_ar_held", arvalid, 1);
    step(); arready = 0;
    step(); rvalid = 1; rlast = 1; rdata = 32'hDEADBEEF;
    @(negedge clk); chk("t1_rd", {data_data_ok, data_rdata}, {1'b1, 32'hDEADBEEF});
    step(); rvalid = 0; rlast = 0;
    // byte write, AW and W same cycle
    req(1, 0, 32'h0000_0103, 32'hAB00_0000);
    step(); data_req = 0; awready = 1; wready = 1;
    @(negedge clk); chk("t2_strb_size", {wstrb, awsize}, {4'b1000, 3'd0});
    step(); awready = 0; wready = 0; bvalid = 1;
    @(negedge clk); chk("t2_dok", data_data_ok, 1);
    step(); bvalid = 0;
    // word write, W three cycles before AW
    req(1, 2, 32'h0000_0200, 32'hCAFE_F00D);
    step(); data_req = 0; wready = 1;
    step(); wready = 0;
    @(negedge clk); chk("t3_w_drop", {wvalid, awvalid}, 2'b01);
    step(); step(); awready = 1;
    @(negedge clk); chk("t3_no_bready", bready, 0);
    step(); awready = 0; bvalid = 1;
    @(negedge clk); chk("t3_dok", {bready, data_data_ok}, 2'b11);
    step(); bvalid = 0;
    // half write at ...2 with SLVERR
    req(1, 1, 32'h0000_0202, 32'hBEEF_0000);
    step(); data_req = 0; awready = 1; wready = 1;
    @(negedge clk); chk("t4_strb", wstrb, 4'b1100);
    step(); awready = 0; wready = 0; bvalid = 1; bresp = 2'b10;
    @(negedge clk); chk("t4_dok", data_data_ok, 1);
    step(); bvalid = 0; bresp = 0;
    @(negedge clk); chk("t4_idle", {bready, awvalid, wvalid}, 0);
    // data_req held: read then write back-to-back
    step(); req(0, 3, 32'h0000_0040, 0); arready = 1;
    step();
    step(); arready = 0; rvalid = 1; rlast = 1; rdata = 32'h1234_5678;
    @(negedge clk); chk("t5_dok_no_aok", {data_data_ok, data_addr_ok}, 2'b10);
    step(); rvalid = 0; rlast = 0; req(1, 2, 32'h0000_0080, 32'h55AA_55AA);
    @(negedge clk); chk("t5_aok2", {data_addr_ok, arvalid, awvalid}, 3'b100);
    step(); data_req = 0; awready = 1; wready = 1;
    @(negedge clk); chk("t5_no_ar", arvalid, 0);
    step(); awready = 0; wready = 0; bvalid = 1;
    @(negedge clk); chk("t5_dok2", data_data_ok, 1);
    step(); bvalid = 0;
    // reset in RD_DATA
    req(0, 2, 32'h0000_1000, 0);
    step(); data_req = 0; arready = 1;
    step(); arready = 0; rvalid = 1; rlast = 1; rdata = 32'h0BAD_0BAD;
    #1 chk("t6_pre", {rready, data_data_ok}, 2'b11);
    #1 rst = 1;
    #1 chk("t6_async", {arvalid, rready, data_data_ok}, 0);
    step(); rvalid = 0; rlast = 0;
    step(); rst = 0; req(0, 2, 32'h0000_2000, 0);
    step(); data_req = 0;
    @(negedge clk); chk("t6_araddr", {arvalid, araddr}, {1'b1, 32'h0000_2000});
    step(); arready = 1;
    step(); arready = 0; rvalid = 1; rlast = 1; rdata = 32'h7777_0001;
    @(negedge clk); chk("t6_rd", {data_data_ok, data_rdata}, {1'b1, 32'h7777_0001});
    step(); rvalid = 0; rlast = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
